// File: rtl/fwd_hazard_unit_if.sv
// Bundle of the ID-stage instruction fields, the data-memory ready flag and
// the forwarding / hazard control outputs of fwd_hazard_unit.
//
// Handshake: there is no valid/ready pair on this bus.
//   - id_valid qualifies the id_* fields for the current cycle.
//   - mem_ready=1 means the pipeline advances on the next clock edge.
//   - mem_ready=0 freezes every stage. A consumer sees stall=1 and must hold
//     PC and IF/ID until stall drops.
//
// Signals:
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
//   id_reg_write, id_mem_read : instruction currently in ID
//   mem_ready                 : data memory access complete
//   fwd_sel_a/b               : registered EX operand mux selects
//                               00 = register file, 01 = EX/MEM, 10 = MEM/WB
//   stall, bubble             : combinational pipeline control
//   stall_cnt                 : saturating count of stalled cycles
//   dbg_state                 : FSM state, exposed for observation
//   dbg_wb                    : WB shadow {valid, rd, reg_write, mem_read}
interface fwd_hazard_unit_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic              id_valid;
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [RA_W-1:0]   id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              mem_ready;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic              stall;
  logic              bubble;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        dbg_state;
  logic [RA_W+2:0]   dbg_wb;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, mem_ready,
    input  fwd_sel_a, fwd_sel_b, stall, bubble, stall_cnt, dbg_state, dbg_wb
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, mem_ready,
    output fwd_sel_a, fwd_sel_b, stall, bubble, stall_cnt, dbg_state, dbg_wb
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard control for the RISC-V PE pipeline.
//
// The unit shadows {valid, rd, reg_write, mem_read} of the instructions in
// EX, MEM and WB. From these it:
//   - registers the EX operand mux selects for the instruction leaving ID;
//   - detects load-use hazards and inserts a one-cycle bubble;
//   - freezes on data-memory wait.
//
// Ports:
//   clk : pipeline clock
//   rst : asynchronous active-high reset
//   bus : fwd_hazard_unit_if.slave. It carries the ID fields and mem_ready in,
//         and fwd_sel_a/b, stall, bubble, stall_cnt and the debug state out.
module fwd_hazard_unit #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  fwd_hazard_unit_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
  } shadow_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_MWAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  shadow_t          ex_q, mem_q, wb_q;
  shadow_t          ex_d;
  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance;
  logic             lu;
  logic             stall;
  logic             bubble;
  logic             hit_rs1;
  logic             hit_rs2;

  // The instruction now in EX sits in EX/MEM when the ID instruction
  // reaches EX, so it maps to 01. The one in MEM maps to 10.
  // The EX check comes first so the newest writer wins.
  function automatic logic [1:0] pick_src(input logic            used,
                                          input logic [RA_W-1:0] rs,
                                          input shadow_t         ex,
                                          input shadow_t         mem);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (rs != '0)) begin
      if (ex.valid && ex.reg_write && (ex.rd == rs)) begin
        sel = 2'b01;
      end else if (mem.valid && mem.reg_write && (mem.rd == rs)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  assign advance = bus.mem_ready;

  always_comb begin
    hit_rs1 = bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd);
    hit_rs2 = bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd);
    lu      = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid &&
              (hit_rs1 || hit_rs2);
    // A freeze takes priority: no bubble while memory is waiting.
    // The hazard is seen again once mem_ready returns.
    stall   = !rst && (lu || !bus.mem_ready);
    bubble  = !rst && lu && bus.mem_ready;
  end

  always_comb begin
    ex_d.valid     = bus.id_valid && !bubble;
    ex_d.rd        = bus.id_rd;
    ex_d.reg_write = bus.id_reg_write;
    ex_d.mem_read  = bus.id_mem_read;

    if (bubble) begin
      sel_a_d = 2'b00;
      sel_b_d = 2'b00;
    end else begin
      sel_a_d = pick_src(bus.id_use_rs1, bus.id_rs1, ex_q, mem_q);
      sel_b_d = pick_src(bus.id_use_rs2, bus.id_rs2, ex_q, mem_q);
    end

    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Leaving MWAIT with a pending load-use goes to LSTALL. The bubble is
  // inserted on that same edge, so LSTALL keeps its meaning.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (!bus.mem_ready) begin
          state_d = ST_MWAIT;
        end else if (lu) begin
          state_d = ST_LSTALL;
        end
      end
      ST_LSTALL: begin
        if (!bus.mem_ready) begin
          state_d = ST_MWAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MWAIT: begin
        if (bus.mem_ready) begin
          state_d = lu ? ST_LSTALL : ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (advance) begin
        wb_q    <= mem_q;
        mem_q   <= ex_q;
        ex_q    <= ex_d;
        sel_a_q <= sel_a_d;
        sel_b_q <= sel_b_d;
      end
    end
  end

  assign bus.fwd_sel_a = sel_a_q;
  assign bus.fwd_sel_b = sel_b_q;
  assign bus.stall     = stall;
  assign bus.bubble    = bubble;
  assign bus.stall_cnt = cnt_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_wb    = wb_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int RA_W    = 5;
  localparam int CNT_W   = 16;
  localparam int SMALL_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit_if #(.RA_W(RA_W), .CNT_W(CNT_W))   bus ();
  fwd_hazard_unit_if #(.RA_W(RA_W), .CNT_W(SMALL_W)) sbus ();

  fwd_hazard_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter copy driven with identical stimulus, to observe saturation.
  fwd_hazard_unit #(.RA_W(RA_W), .CNT_W(SMALL_W)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  assign sbus.id_valid     = bus.id_valid;
  assign sbus.id_rs1       = bus.id_rs1;
  assign sbus.id_rs2       = bus.id_rs2;
  assign sbus.id_use_rs1   = bus.id_use_rs1;
  assign sbus.id_use_rs2   = bus.id_use_rs2;
  assign sbus.id_rd        = bus.id_rd;
  assign sbus.id_reg_write = bus.id_reg_write;
  assign sbus.id_mem_read  = bus.id_mem_read;
  assign sbus.mem_ready    = bus.mem_ready;

  // ---------------- reference model ----------------
  typedef struct {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       rw;
    logic       ld;
  } instr_t;

  instr_t      ex_m, mem_m, wb_m;       // in-flight instructions, oldest last
  int unsigned stall_total;             // stalled cycles since reset
  logic        last_stall;
  logic [3:0]  exp_q[$];                // expected {sel_a, sel_b} for the next cycle

  function automatic instr_t mk(input logic v, input int rd, input int rs1,
                                input int rs2, input logic u1, input logic u2,
                                input logic rw, input logic ld);
    instr_t i;
    i.valid = v;
    i.rd    = 5'(rd);
    i.rs1   = 5'(rs1);
    i.rs2   = 5'(rs2);
    i.use1  = u1;
    i.use2  = u2;
    i.rw    = rw;
    i.ld    = ld;
    return i;
  endfunction

  // Distance to the nearest older in-flight writer of rs.
  // Distance 1 gives 01, distance 2 gives 10, and none gives 00.
  function automatic logic [1:0] fwd_code(input logic [4:0] rs, input logic used);
    instr_t ahead[2];
    ahead[0] = ex_m;
    ahead[1] = mem_m;
    if (!used || rs == 5'd0) return 2'b00;
    for (int d = 0; d < 2; d++) begin
      if (ahead[d].valid && ahead[d].rw && ahead[d].rd == rs) return 2'(d + 1);
    end
    return 2'b00;
  endfunction

  // A consumer right behind a load to a nonzero register must wait.
  function automatic logic load_use(input instr_t id);
    logic reads;
    reads = (id.use1 && id.rs1 == ex_m.rd) || (id.use2 && id.rs2 == ex_m.rd);
    return ex_m.valid && ex_m.ld && ex_m.rd != 5'd0 && id.valid && reads;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_id(input instr_t i);
    bus.id_valid     = i.valid;
    bus.id_rd        = i.rd;
    bus.id_rs1       = i.rs1;
    bus.id_rs2       = i.rs2;
    bus.id_use_rs1   = i.use1;
    bus.id_use_rs2   = i.use2;
    bus.id_reg_write = i.rw;
    bus.id_mem_read  = i.ld;
  endtask

  // One pipeline cycle: drive at negedge, check, then advance the model
  // past the coming posedge.
  task automatic step(input instr_t i, input logic mr);
    logic       lu, exp_stall, exp_bubble;
    logic [3:0] cur_sel, next_sel;
    @(negedge clk);
    drive_id(i);
    bus.mem_ready = mr;
    #1;
    lu         = load_use(i);
    exp_stall  = lu || !mr;
    exp_bubble = lu && mr;
    check_eq("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
    check_eq("bubble", {31'd0, bus.bubble}, {31'd0, exp_bubble});
    if (exp_q.size() == 0) begin
      check_eq("sel_queue_empty", 32'(exp_q.size()), 32'd1);
      cur_sel = 4'd0;
    end else begin
      cur_sel = exp_q.pop_front();
    end
    check_eq("fwd_sel_a", {30'd0, bus.fwd_sel_a}, {30'd0, cur_sel[3:2]});
    check_eq("fwd_sel_b", {30'd0, bus.fwd_sel_b}, {30'd0, cur_sel[1:0]});
    check_eq("stall_cnt", 32'(bus.stall_cnt), sat(stall_total, 65535));
    check_eq("stall_cnt_sat", 32'(sbus.stall_cnt), sat(stall_total, 3));
    if (exp_stall) stall_total++;
    if (mr) begin
      next_sel = exp_bubble ? 4'd0 : {fwd_code(i.rs1, i.use1), fwd_code(i.rs2, i.use2)};
      wb_m     = mem_m;
      mem_m    = ex_m;
      ex_m     = i;
      ex_m.valid = i.valid && !exp_bubble;
      exp_q.push_back(next_sel);
    end else begin
      exp_q.push_back(cur_sel);
    end
    last_stall = exp_stall;
  endtask

  // Present an instruction and hold it in ID until it is accepted.
  task automatic issue(input instr_t i);
    int guard;
    step(i, 1'b1);
    guard = 0;
    while (last_stall && guard < 8) begin
      step(i, 1'b1);
      guard++;
    end
    check_eq("stall_timeout", {31'd0, last_stall}, 32'd0);
  endtask

  // Asserts reset asynchronously and checks it. Releases it shortly after a
  // posedge, so that no clock edge falls before the next step drives.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
    check_eq("rst_bubble", {31'd0, bus.bubble}, 32'd0);
    check_eq("rst_sel_a", {30'd0, bus.fwd_sel_a}, 32'd0);
    check_eq("rst_sel_b", {30'd0, bus.fwd_sel_b}, 32'd0);
    check_eq("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    check_eq("rst_cnt_sat", 32'(sbus.stall_cnt), 32'd0);
    ex_m.valid  = 1'b0;
    mem_m.valid = 1'b0;
    wb_m.valid  = 1'b0;
    stall_total = 0;
    last_stall  = 1'b0;
    exp_q.delete();
    exp_q.push_back(4'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  instr_t nop;
  instr_t cur;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    ex_m = nop; mem_m = nop; wb_m = nop;
    drive_id(nop);
    bus.mem_ready = 1'b0;   // stall must stay low in reset even with memory busy
    do_reset();

    // ALU chain: add x5,x1,x2 ; sub x6,x5,x1
    issue(mk(1, 5, 1, 2, 1, 1, 1, 0));
    issue(mk(1, 6, 5, 1, 1, 1, 1, 0));
    issue(nop);
    check_eq("alu_chain_a", {30'd0, bus.fwd_sel_a}, 32'd1);
    check_eq("alu_chain_b", {30'd0, bus.fwd_sel_b}, 32'd0);

    // Distance-2 dependency, then both EX and MEM writing x7
    issue(mk(1, 7, 1, 2, 1, 1, 1, 0));
    issue(nop);
    issue(mk(1, 8, 2, 7, 1, 1, 1, 0));
    issue(nop);
    check_eq("dist2_b", {30'd0, bus.fwd_sel_b}, 32'd2);
    issue(mk(1, 7, 1, 2, 1, 1, 1, 0));
    issue(mk(1, 7, 3, 4, 1, 1, 1, 0));
    issue(mk(1, 8, 2, 7, 1, 1, 1, 0));
    issue(nop);
    check_eq("newest_wins_b", {30'd0, bus.fwd_sel_b}, 32'd1);

    // Load-use: lw x9 ; add x10,x9,x9
    do_reset();
    issue(mk(1, 9, 2, 0, 1, 0, 1, 1));
    issue(mk(1, 10, 9, 9, 1, 1, 1, 0));
    issue(nop);
    check_eq("lu_sel_a", {30'd0, bus.fwd_sel_a}, 32'd2);
    check_eq("lu_sel_b", {30'd0, bus.fwd_sel_b}, 32'd2);
    check_eq("lu_cnt", 32'(bus.stall_cnt), 32'd1);

    // x0 writer and reader; load with an unused matching rs2
    issue(mk(1, 0, 1, 2, 1, 1, 1, 0));
    issue(mk(1, 4, 0, 0, 1, 1, 1, 0));
    issue(nop);
    check_eq("x0_sel_a", {30'd0, bus.fwd_sel_a}, 32'd0);
    issue(mk(1, 3, 1, 0, 1, 0, 1, 1));
    step(mk(1, 11, 4, 3, 1, 0, 1, 0), 1'b1);
    check_eq("unused_rs2_stall", {31'd0, bus.stall}, 32'd0);
    issue(nop);

    // Memory wait for 3 cycles inside the ALU chain
    issue(mk(1, 5, 1, 2, 1, 1, 1, 0));
    cur = mk(1, 6, 5, 1, 1, 1, 1, 0);
    repeat (3) step(cur, 1'b0);
    issue(cur);
    issue(nop);
    check_eq("mwait_sel_a", {30'd0, bus.fwd_sel_a}, 32'd1);

    // Async reset in the middle of a load-use stall
    issue(mk(1, 9, 2, 0, 1, 0, 1, 1));
    step(mk(1, 10, 9, 9, 1, 1, 1, 0), 1'b1);
    check_eq("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
    #1;
    do_reset();
    issue(mk(1, 10, 9, 9, 1, 1, 1, 0));

    // Randomized traffic over a small register set to provoke hazards
    cur = nop;
    for (int n = 0; n < 500; n++) begin
      logic ld;
      if (!last_stall) begin
        ld  = ($urandom_range(0, 2) == 0);
        cur = mk(($urandom_range(0, 9) != 0), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ld | 1'($urandom_range(0, 1)), ld);
      end
      step(cur, ($urandom_range(0, 5) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
